syncword_corr: RTL and testbench
================================

Name: syncword_corr

Overview:
- Receive-side access-code correlator directly upstream of the bit-processing stage (header/payload decode).
- Samples the demodulated bit stream on the 1 µs strobe and searches a bounded window for the expected 64-bit sync word, tolerating up to a programmable number of bit errors.
- On a hit, tracks the 4-bit trailer and issues `rx_trailer_st_p`, which the header decoder uses as its start reference.
- Forwards the aligned sampled bit as `rxbit`.

Parameters:
- SW_LEN, 64, sync word length in bits (fixed by protocol; not tested at other values).
- TRL_LEN, 4, trailer length in bits.

Ports:
- clk_6M, input, 1, system clock, 6 MHz.
- rstz, input, 1, reset, asynchronous, active-low.
- p_1us, input, 1, one-cycle strobe every 1 µs (bit-sample instant).
- rxbit_in, input, 1, raw demodulated bit from the radio interface.
- corr_en, input, 1, level; high = search/track active, low = abort to IDLE.
- regi_syncword, input, 64, expected sync word. Bit 0 is transmitted first. The parent mux selects CAC/DAC/GIAC/DIAC.
- regi_corr_thresh, input, 7, maximum accepted Hamming distance (0..64).
- regi_corr_window, input, 10, search window length in µs; 0 = unlimited.
- rxbit, output, 1, most recently sampled bit, i.e. `shreg[63]`.
- sync_found_p, output, 1, one-cycle pulse on sync word acceptance.
- sync_timeout_p, output, 1, one-cycle pulse when the window expires without a hit.
- rx_trailer_st_p, output, 1, one-cycle pulse at trailer start.
- rx_locked, output, 1, high after the trailer completes, until abort.
- rx_err_cnt, output, 7, Hamming distance latched at acceptance.

Behaviour:

Reset:
- All outputs are 0.
- `shreg` = 0; state = IDLE; all counters 0.

Sampling and alignment:
- On every `p_1us` cycle (any state except IDLE), shift: `shreg <= {rxbit_in, shreg[63:1]}`.
- After 64 shifts, `shreg[0]` holds the first received bit and aligns with `regi_syncword[0]`.
- `rxbit` = `shreg[63]`, so it is valid from the cycle after the strobe.

Correlation:
- `mism` = popcount(`shreg` XOR `regi_syncword`), 7 bits, combinational.
- Evaluated only in the cycle after a `p_1us` strobe (`p1d`).

State machine (IDLE, SEARCH, TRAILER, LOCKED):
- IDLE → SEARCH when `corr_en` = 1.
  - On entry, clear `shreg`, `bitcnt` (7 bits, saturates at 64) and `wincnt` (10 bits).
- SEARCH, each `p_1us`: shift; increment `bitcnt` (saturating at 64) and `wincnt`.
- SEARCH, at `p1d`:
  - If `bitcnt` == 64 and `mism` <= `regi_corr_thresh`: go to TRAILER, pulse `sync_found_p`, latch `rx_err_cnt` = `mism`, clear `trlcnt`.
  - Else if `regi_corr_window` != 0 and `wincnt` >= `regi_corr_window`: go to IDLE and pulse `sync_timeout_p`.
  - If a match and a timeout occur at the same `p1d`, the match wins.
- TRAILER:
  - Each `p_1us` increments `trlcnt` (2 bits).
  - `rx_trailer_st_p` pulses in the cycle after the first trailer strobe (`trlcnt` 0→1).
  - After the 4th strobe, go to LOCKED.
- LOCKED:
  - `rx_locked` = 1; `rxbit` keeps following the samples.
  - No further correlation.

Abort and window rules:
- `corr_en` = 0 in any state → IDLE on the next clock.
  - No pulses are generated.
  - `rx_locked` clears the next cycle.
  - `rx_err_cnt` holds its value.
- Holding `corr_en` high after a timeout restarts the search the next cycle, with a fresh window.
- Matches with `bitcnt` < 64 are impossible; zero-filled history cannot alias.
- `regi_*` inputs are sampled live; software changes them only while `corr_en` = 0.

Latency:
- Last sync bit strobe → `sync_found_p`: 1 clock.
- First trailer strobe → `rx_trailer_st_p`: 1 clock.

Test Plan:
1. Exact hit:
   - Stimulus: `corr_en` = 1, window 0, thresh 0, `regi_syncword` = 64'h4E7E_1A2B_9C3D_5F60; send 10 random bits, the word LSB-first, then trailer 1010.
   - Required: `sync_found_p` exactly 1 cycle after the 74th strobe; `rx_err_cnt` = 0; `rx_trailer_st_p` 1 cycle after the 75th strobe; `rx_locked` = 1 after the 78th.
2. Error tolerance:
   - Stimulus: same word with 7 bits flipped; thresh 7, then repeat with thresh 6.
   - Required: thresh 7 → hit with `rx_err_cnt` = 7; thresh 6 → no hit.
3. Timeout:
   - Stimulus: window 100, random data with no match.
   - Required: `sync_timeout_p` 1 cycle after strobe 100; state IDLE; `rx_trailer_st_p` never asserted.
4. Simultaneous match and timeout:
   - Stimulus: window 64, word sent from the first strobe.
   - Required: `sync_found_p` = 1 and `sync_timeout_p` = 0 at that `p1d`.
5. Abort:
   - Stimulus: drop `corr_en` during TRAILER after 2 trailer bits.
   - Required: no `rx_locked`; all pulses 0; re-enable → `shreg` cleared, a new 64-bit fill is required before a hit.
6. Reset mid-lock:
   - Stimulus: assert `rstz` = 0 asynchronously while LOCKED.
   - Required: all outputs 0 immediately; state IDLE after release.

Source files
------------

// File: rtl/syncword_corr.sv
// Access-code correlator: searches the sampled bit stream for the sync word
// within a bounded window, then tracks the trailer and reports lock.
module syncword_corr #(
  parameter int SW_LEN  = 64,
  parameter int TRL_LEN = 4
) (
  input  logic              clk_6M,
  input  logic              rstz,
  input  logic              p_1us,
  input  logic              rxbit_in,
  input  logic              corr_en,
  input  logic [SW_LEN-1:0] regi_syncword,
  input  logic [6:0]        regi_corr_thresh,
  input  logic [9:0]        regi_corr_window,
  output logic              rxbit,
  output logic              sync_found_p,
  output logic              sync_timeout_p,
  output logic              rx_trailer_st_p,
  output logic              rx_locked,
  output logic [6:0]        rx_err_cnt
);

  typedef enum logic [1:0] {IDLE, SEARCH, TRAILER, LOCKED} state_t;

  state_t            state;
  logic [SW_LEN-1:0] shreg;
  logic [SW_LEN-1:0] shreg_nxt;
  logic [6:0]        bitcnt;
  logic [6:0]        bitcnt_nxt;
  logic [6:0]        mism_nxt;
  logic [9:0]        wincnt;
  logic [9:0]        wincnt_nxt;
  logic [1:0]        trlcnt;

  function automatic logic [6:0] popcount(input logic [SW_LEN-1:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < SW_LEN; i++) c = c + {6'd0, v[i]};
    return c;
  endfunction

  // The match decision is taken on the post-shift value at the strobe edge,
  // so the registered pulses appear in the cycle right after the strobe.
  always_comb begin
    shreg_nxt  = {rxbit_in, shreg[SW_LEN-1:1]};
    bitcnt_nxt = (bitcnt == 7'(SW_LEN)) ? bitcnt : bitcnt + 7'd1;
    wincnt_nxt = wincnt + 10'd1;
    mism_nxt   = popcount(shreg_nxt ^ regi_syncword);
  end

  assign rxbit = shreg[SW_LEN-1];

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      state           <= IDLE;
      shreg           <= '0;
      bitcnt          <= '0;
      wincnt          <= '0;
      trlcnt          <= '0;
      sync_found_p    <= 1'b0;
      sync_timeout_p  <= 1'b0;
      rx_trailer_st_p <= 1'b0;
      rx_locked       <= 1'b0;
      rx_err_cnt      <= '0;
    end else begin
      sync_found_p    <= 1'b0;
      sync_timeout_p  <= 1'b0;
      rx_trailer_st_p <= 1'b0;
      if (!corr_en) begin
        state     <= IDLE;
        rx_locked <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state  <= SEARCH;
            shreg  <= '0;
            bitcnt <= '0;
            wincnt <= '0;
          end
          SEARCH: begin
            if (p_1us) begin
              shreg  <= shreg_nxt;
              bitcnt <= bitcnt_nxt;
              wincnt <= wincnt_nxt;
              if (bitcnt_nxt == 7'(SW_LEN) && mism_nxt <= regi_corr_thresh) begin
                state        <= TRAILER;
                sync_found_p <= 1'b1;
                rx_err_cnt   <= mism_nxt;
                trlcnt       <= '0;
              end else if (regi_corr_window != '0 && wincnt_nxt >= regi_corr_window) begin
                state          <= IDLE;
                sync_timeout_p <= 1'b1;
              end
            end
          end
          TRAILER: begin
            if (p_1us) begin
              shreg  <= shreg_nxt;
              trlcnt <= trlcnt + 2'd1;
              if (trlcnt == 2'd0) rx_trailer_st_p <= 1'b1;
              if (trlcnt == 2'(TRL_LEN - 1)) begin
                state     <= LOCKED;
                rx_locked <= 1'b1;
              end
            end
          end
          LOCKED: begin
            if (p_1us) shreg <= shreg_nxt;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_syncword_corr.sv
// Scoreboard bench for syncword_corr: per-strobe expected outputs are queued
// when a bit is driven and compared in the cycle after the strobe.
`timescale 1ns/1ps
module tb_syncword_corr;

  logic        clk_6M = 1'b0;
  logic        rstz;
  logic        p_1us;
  logic        rxbit_in;
  logic        corr_en;
  logic [63:0] regi_syncword;
  logic [6:0]  regi_corr_thresh;
  logic [9:0]  regi_corr_window;
  logic        rxbit;
  logic        sync_found_p;
  logic        sync_timeout_p;
  logic        rx_trailer_st_p;
  logic        rx_locked;
  logic [6:0]  rx_err_cnt;

  typedef struct packed {
    logic found;
    logic timeout;
    logic trl;
    logic locked;
    logic rxb;
  } exp_t;

  exp_t        sb[$];
  int          n_checks  = 0;
  int          n_errors  = 0;
  int          strobe_no = 0;
  logic [63:0] word;
  logic [63:0] flipped;
  logic [63:0] two_flip;
  logic [9:0]  prefix;
  logic [3:0]  trl_bits;

  syncword_corr dut (
    .clk_6M          (clk_6M),
    .rstz            (rstz),
    .p_1us           (p_1us),
    .rxbit_in        (rxbit_in),
    .corr_en         (corr_en),
    .regi_syncword   (regi_syncword),
    .regi_corr_thresh(regi_corr_thresh),
    .regi_corr_window(regi_corr_window),
    .rxbit           (rxbit),
    .sync_found_p    (sync_found_p),
    .sync_timeout_p  (sync_timeout_p),
    .rx_trailer_st_p (rx_trailer_st_p),
    .rx_locked       (rx_locked),
    .rx_err_cnt      (rx_err_cnt)
  );

  always #83 clk_6M = ~clk_6M;

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One 1 us bit period: strobe for one clock, then five idle clocks.
  task automatic applyStimulus(input logic b, input logic ef, input logic et,
                               input logic etr, input logic el);
    exp_t e;
    exp_t got;
    @(negedge clk_6M);
    rxbit_in = b;
    p_1us    = 1'b1;
    strobe_no++;
    e = '{found: ef, timeout: et, trl: etr, locked: el, rxb: b};
    sb.push_back(e);
    @(negedge clk_6M);
    p_1us = 1'b0;
    got = '{found: sync_found_p, timeout: sync_timeout_p, trl: rx_trailer_st_p,
            locked: rx_locked, rxb: rxbit};
    checkOutput("sb_size", 16'(sb.size()), 16'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checkOutput($sformatf("strobe%0d_fnd_to_trl_lck_rxb", strobe_no),
                  {11'd0, got}, {11'd0, e});
    end
    @(negedge clk_6M);
    checkOutput("pulse_clear", {13'd0, sync_found_p, sync_timeout_p, rx_trailer_st_p}, 16'd0);
    repeat (3) @(negedge clk_6M);
  endtask

  task automatic setIdle();
    @(negedge clk_6M);
    corr_en = 1'b0;
    repeat (3) @(negedge clk_6M);
  endtask

  task automatic startSearch(input logic [6:0] thresh, input logic [9:0] window);
    @(negedge clk_6M);
    regi_syncword    = word;
    regi_corr_thresh = thresh;
    regi_corr_window = window;
    @(negedge clk_6M);
    corr_en = 1'b1;
    repeat (2) @(negedge clk_6M);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    word     = 64'h4E7E_1A2B_9C3D_5F60;
    prefix   = 10'b1100101001;
    flipped  = word;
    flipped[0]  = ~flipped[0];
    flipped[5]  = ~flipped[5];
    flipped[13] = ~flipped[13];
    flipped[22] = ~flipped[22];
    flipped[40] = ~flipped[40];
    flipped[51] = ~flipped[51];
    flipped[63] = ~flipped[63];
    two_flip = word;
    two_flip[10] = ~two_flip[10];
    two_flip[30] = ~two_flip[30];

    rstz = 1'b0; p_1us = 1'b0; rxbit_in = 1'b0; corr_en = 1'b0;
    regi_syncword = '0; regi_corr_thresh = '0; regi_corr_window = '0;
    repeat (3) @(negedge clk_6M);
    checkOutput("reset_outputs", {4'd0, rxbit, sync_found_p, sync_timeout_p,
                rx_trailer_st_p, rx_locked, rx_err_cnt}, 16'd0);
    rstz = 1'b1;
    repeat (3) @(negedge clk_6M);
    checkOutput("idle_outputs", {4'd0, rxbit, sync_found_p, sync_timeout_p,
                rx_trailer_st_p, rx_locked, rx_err_cnt}, 16'd0);

    $display("[TB] exact hit");
    startSearch(7'd0, 10'd0);
    for (int i = 0; i < 10; i++) applyStimulus(prefix[i], 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) applyStimulus(word[i], i == 63, 1'b0, 1'b0, 1'b0);
    checkOutput("exact_err_cnt", {9'd0, rx_err_cnt}, 16'd0);
    trl_bits = 4'b0101;
    for (int i = 0; i < 4; i++) applyStimulus(trl_bits[i], 1'b0, 1'b0, i == 0, i == 3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("[TB] error tolerance thresh 7");
    setIdle();
    startSearch(7'd7, 10'd0);
    for (int i = 0; i < 64; i++) applyStimulus(flipped[i], i == 63, 1'b0, 1'b0, 1'b0);
    checkOutput("tol7_err_cnt", {9'd0, rx_err_cnt}, 16'd7);

    $display("[TB] error tolerance thresh 6");
    setIdle();
    startSearch(7'd6, 10'd0);
    for (int i = 0; i < 64; i++) applyStimulus(flipped[i], 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("tol6_err_hold", {9'd0, rx_err_cnt}, 16'd7);

    $display("[TB] timeout and fresh window");
    setIdle();
    startSearch(7'd0, 10'd100);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 100; i++)
        applyStimulus(1'($urandom_range(0, 1)), 1'b0, i == 99, 1'b0, 1'b0);

    $display("[TB] simultaneous match and timeout");
    setIdle();
    startSearch(7'd0, 10'd64);
    for (int i = 0; i < 64; i++) applyStimulus(word[i], i == 63, 1'b0, 1'b0, 1'b0);
    checkOutput("simul_err_cnt", {9'd0, rx_err_cnt}, 16'd0);

    $display("[TB] abort during trailer");
    setIdle();
    startSearch(7'd0, 10'd0);
    for (int i = 0; i < 64; i++) applyStimulus(word[i], i == 63, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(word[i], 1'b0, 1'b0, i == 0, 1'b0);
    @(negedge clk_6M);
    corr_en = 1'b0;
    repeat (2) @(negedge clk_6M);
    checkOutput("abort_quiet", {12'd0, sync_found_p, sync_timeout_p, rx_trailer_st_p, rx_locked}, 16'd0);
    @(negedge clk_6M);
    corr_en = 1'b1;
    repeat (2) @(negedge clk_6M);
    for (int i = 2; i < 64; i++) applyStimulus(word[i], 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) applyStimulus(word[i], i == 63, 1'b0, 1'b0, 1'b0);

    $display("[TB] async reset while locked");
    setIdle();
    startSearch(7'd3, 10'd0);
    for (int i = 0; i < 64; i++) applyStimulus(two_flip[i], i == 63, 1'b0, 1'b0, 1'b0);
    checkOutput("relock_err_cnt", {9'd0, rx_err_cnt}, 16'd2);
    trl_bits = 4'b1010;
    for (int i = 0; i < 4; i++) applyStimulus(trl_bits[i], 1'b0, 1'b0, i == 0, i == 3);
    @(negedge clk_6M);
    #20 rstz = 1'b0;
    #1;
    checkOutput("async_reset_outputs", {4'd0, rxbit, sync_found_p, sync_timeout_p,
                rx_trailer_st_p, rx_locked, rx_err_cnt}, 16'd0);
    @(negedge clk_6M);
    rstz = 1'b1;
    repeat (2) @(negedge clk_6M);
    for (int i = 0; i < 64; i++) applyStimulus(word[i], i == 63, 1'b0, 1'b0, 1'b0);
    checkOutput("post_reset_err_cnt", {9'd0, rx_err_cnt}, 16'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
